// File: rtl/regfile_multi.sv
// rtl/regfile_multi.sv - parametrised 2R/1W register file with clear sweep; optional bypass via REGFILE_BYPASS_EN
module regfile_multi #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_write_en,
  input  logic [ADDR_W-1:0] reg_write_des,
  input  logic [DATA_W-1:0] reg_write_data,
  input  logic [ADDR_W-1:0] reg_read_addr_1,
  input  logic [ADDR_W-1:0] reg_read_addr_2,
  output logic [DATA_W-1:0] reg_read_data_1,
  output logic [DATA_W-1:0] reg_read_data_2,
  input  logic              clear_req,
  output logic              busy,
  output logic              clear_done,
  output logic              write_rejected
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic              sweep_last;
  logic              wr_ok;
  logic [DATA_W-1:0] mem [DEPTH];

  // Writes to the hardwired zero register are dropped silently, and nothing is written during a sweep
  assign wr_ok      = reg_write_en && !busy && !(ZERO_REG != 0 && reg_write_des == '0);
  assign sweep_last = busy && (cnt == LAST_ADDR);

  // State register for the clear engine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and busy decode; clear_req is only looked at in IDLE so a sweep cannot restart
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (clear_req) state_nxt = CLEAR;
      end
      CLEAR: begin
        busy = 1'b1;
        if (cnt == LAST_ADDR) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sweep pointer: held at 0 while idle, steps once per sweep cycle and wraps to 0 on the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (busy) cnt <= cnt + 1'b1;
    else           cnt <= '0;
  end

  // Register array: sweep zeroing has priority; normal writes only land while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (busy) begin
      mem[cnt] <= '0;
    end else if (wr_ok) begin
      mem[reg_write_des] <= reg_write_data;
    end
  end

  // Status pulses: done in the first idle cycle after the sweep, rejection the cycle after a busy write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clear_done     <= 1'b0;
      write_rejected <= 1'b0;
    end else begin
      clear_done     <= sweep_last;
      write_rejected <= reg_write_en && busy;
    end
  end

  // Read port 1: array lookup, optional same-cycle forward of the pending write, zero register forced last
  always_comb begin
    reg_read_data_1 = mem[reg_read_addr_1];
`ifdef REGFILE_BYPASS_EN
    if (reg_write_en && !busy && reg_read_addr_1 == reg_write_des) reg_read_data_1 = reg_write_data;
`endif
    if (ZERO_REG != 0 && reg_read_addr_1 == '0) reg_read_data_1 = '0;
  end

  // Read port 2: same structure as port 1, forwarding decided independently
  always_comb begin
    reg_read_data_2 = mem[reg_read_addr_2];
`ifdef REGFILE_BYPASS_EN
    if (reg_write_en && !busy && reg_read_addr_2 == reg_write_des) reg_read_data_2 = reg_write_data;
`endif
    if (ZERO_REG != 0 && reg_read_addr_2 == '0) reg_read_data_2 = '0;
  end

endmodule

// File: tb/tb_regfile_multi.sv
// tb/tb_regfile_multi.sv - self-checking bench for regfile_multi (default, ZERO_REG=1, 32x16 instances)
module tb_regfile_multi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we, clr;
  logic [3:0]  des, ra1, ra2;
  logic [31:0] data;

  logic [15:0] rd1_a, rd2_a, rd1_z, rd2_z;
  logic [31:0] rd1_w, rd2_w;
  logic        busy_a, busy_z, busy_w;
  logic        done_a, done_z, done_w;
  logic        rej_a, rej_z, rej_w;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  always #5 clk = ~clk;

  regfile_multi u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .reg_write_en(we), .reg_write_des(des[2:0]), .reg_write_data(data[15:0]),
    .reg_read_addr_1(ra1[2:0]), .reg_read_addr_2(ra2[2:0]),
    .reg_read_data_1(rd1_a), .reg_read_data_2(rd2_a),
    .clear_req(clr), .busy(busy_a), .clear_done(done_a), .write_rejected(rej_a)
  );

  regfile_multi #(.ZERO_REG(1)) u_dut_z (
    .clk(clk), .rst_n(rst_n),
    .reg_write_en(we), .reg_write_des(des[2:0]), .reg_write_data(data[15:0]),
    .reg_read_addr_1(ra1[2:0]), .reg_read_addr_2(ra2[2:0]),
    .reg_read_data_1(rd1_z), .reg_read_data_2(rd2_z),
    .clear_req(clr), .busy(busy_z), .clear_done(done_z), .write_rejected(rej_z)
  );

  regfile_multi #(.DATA_W(32), .DEPTH(16)) u_dut_w (
    .clk(clk), .rst_n(rst_n),
    .reg_write_en(we), .reg_write_des(des), .reg_write_data(data),
    .reg_read_addr_1(ra1), .reg_read_addr_2(ra2),
    .reg_read_data_1(rd1_w), .reg_read_data_2(rd2_w),
    .clear_req(clr), .busy(busy_w), .clear_done(done_w), .write_rejected(rej_w)
  );

  // Reference model: one entry per instance (0 = default, 1 = zero reg, 2 = 32x16)
  logic [31:0] mm [3][16];
  int          pos [3];
  bit          mdone [3];
  bit          mrej [3];
  int          dep [3] = '{8, 8, 16};
  int          zr  [3] = '{0, 1, 0};

  function automatic logic [31:0] dmask(int k, logic [31:0] v);
    return (k == 2) ? v : {16'h0, v[15:0]};
  endfunction

  function automatic int amask(int k, logic [3:0] a);
    return int'(a) % dep[k];
  endfunction

  function automatic logic [31:0] exp_rd(int k, logic [3:0] a);
    int ai;
    logic [31:0] v;
    ai = amask(k, a);
    v  = mm[k][ai];
`ifdef REGFILE_BYPASS_EN
    if (we && pos[k] < 0 && ai == amask(k, des)) v = dmask(k, data);
`endif
    if (zr[k] != 0 && ai == 0) v = '0;
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        for (int i = 0; i < 16; i++) mm[k][i] = '0;
        pos[k] = -1; mdone[k] = 1'b0; mrej[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        int wa;
        wa = amask(k, des);
        mrej[k]  = we && pos[k] >= 0;
        mdone[k] = (pos[k] == dep[k] - 1);
        if (pos[k] >= 0) begin
          mm[k][pos[k]] = '0;
          pos[k] = (pos[k] == dep[k] - 1) ? -1 : pos[k] + 1;
        end else begin
          if (we && !(zr[k] != 0 && wa == 0)) mm[k][wa] = dmask(k, data);
          if (clr) pos[k] = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("cmp_rd1_a", {16'h0, rd1_a}, exp_rd(0, ra1));
      chk("cmp_rd2_a", {16'h0, rd2_a}, exp_rd(0, ra2));
      chk("cmp_rd1_z", {16'h0, rd1_z}, exp_rd(1, ra1));
      chk("cmp_rd2_z", {16'h0, rd2_z}, exp_rd(1, ra2));
      chk("cmp_rd1_w", rd1_w, exp_rd(2, ra1));
      chk("cmp_rd2_w", rd2_w, exp_rd(2, ra2));
      chk("cmp_busy_a", busy_a, pos[0] >= 0);
      chk("cmp_busy_z", busy_z, pos[1] >= 0);
      chk("cmp_busy_w", busy_w, pos[2] >= 0);
      chk("cmp_done_a", done_a, mdone[0]);
      chk("cmp_done_z", done_z, mdone[1]);
      chk("cmp_done_w", done_w, mdone[2]);
      chk("cmp_rej_a", rej_a, mrej[0]);
      chk("cmp_rej_z", rej_z, mrej[1]);
      chk("cmp_rej_w", rej_w, mrej[2]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int cnt_a, cnt_z, cnt_w, dn_a, dn_w;
    we = 0; clr = 0; des = 0; data = 0; ra1 = 0; ra2 = 0;
    repeat (2) @(posedge clk);
    #1;
    run_cmp = 1'b1;
    chk("rst_busy_a", busy_a, 1'b0);
    chk("rst_rd1_a", {16'h0, rd1_a}, 32'h0);
    chk("rst_rej_a", rej_a, 1'b0);
    rst_n = 1'b1;
    step();

    // Basic writes R3/R5
    we = 1; des = 3; data = 32'hBEEF; step();
    des = 5; data = 32'h1234; step();
    we = 0; ra1 = 3; ra2 = 5; #1;
    chk("wr_r3_a", {16'h0, rd1_a}, 32'hBEEF);
    chk("wr_r5_a", {16'h0, rd2_a}, 32'h1234);
    chk("wr_r3_w", rd1_w, 32'hBEEF);
    for (int a = 0; a < 8; a++) begin
      if (a != 3 && a != 5) begin
        ra1 = 4'(a); #1;
        chk("other_zero_a", {16'h0, rd1_a}, 32'h0);
      end
    end
    step();

    // Hardwired zero register
    we = 1; des = 0; data = 32'hFFFF; step();
    we = 0; ra1 = 0; #1;
    chk("r0_zero_z", {16'h0, rd1_z}, 32'h0);
    chk("r0_norm_a", {16'h0, rd1_a}, 32'hFFFF);
    chk("r0_norej_z", rej_z, 1'b0);
    we = 1; des = 1; data = 32'h0101; step();
    we = 0; ra1 = 1; #1;
    chk("r1_z", {16'h0, rd1_z}, 32'h0101);
    step();

    // Fill everything, then sweep
    for (int i = 0; i < 16; i++) begin
      we = 1; des = 4'(i); data = 32'h1000 + 32'(i) * 32'h11; step();
    end
    we = 0;
    clr = 1; step();
    clr = 0;
    cnt_a = 0; cnt_z = 0; cnt_w = 0; dn_a = 0; dn_w = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (busy_a) cnt_a++;
      if (busy_z) cnt_z++;
      if (busy_w) cnt_w++;
      if (done_a) dn_a++;
      if (done_w) dn_w++;
      if (cyc == 3) chk("rej_pulse_a", rej_a, 1'b1);
      if (cyc >= 1 && cyc <= 7) begin
        ra1 = 4'(cyc - 1); ra2 = 4'(cyc); #1;
        chk("swept_a", {16'h0, rd1_a}, 32'h0);
        chk("unswept_a", {16'h0, rd2_a}, 32'h1088 + 32'(cyc) * 32'h11);
        chk("swept_w", rd1_w, 32'h0);
        chk("unswept_w", rd2_w, 32'h1000 + 32'(cyc) * 32'h11);
      end
      if (cyc == 2) begin we = 1; des = 2; data = 32'h00AA; end
      if (cyc == 3) begin we = 0; clr = 1; end
      if (cyc == 4) clr = 0;
      step();
    end
    chk("busy_cycles_a", cnt_a, 8);
    chk("busy_cycles_z", cnt_z, 8);
    chk("busy_cycles_w", cnt_w, 16);
    chk("done_count_a", dn_a, 1);
    chk("done_count_w", dn_w, 1);
    ra1 = 2; #1;
    chk("r2_dropped_a", {16'h0, rd1_a}, 32'h0);
    chk("r2_dropped_w", rd1_w, 32'h0);
    step();

    // Same-cycle forwarding
    we = 1; des = 4; data = 32'h5A5A; ra1 = 4; ra2 = 0; #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_a", {16'h0, rd1_a}, 32'h5A5A);
`else
    chk("nobypass_a", {16'h0, rd1_a}, 32'h0);
`endif
    step();
    we = 0; #1;
    chk("after_edge_a", {16'h0, rd1_a}, 32'h5A5A);
    we = 1; des = 0; data = 32'h7777; ra1 = 0; #1;
    chk("bypass_r0_z", {16'h0, rd1_z}, 32'h0);
`ifdef REGFILE_BYPASS_EN
    chk("bypass_r0_a", {16'h0, rd1_a}, 32'h7777);
`else
    chk("bypass_r0_a", {16'h0, rd1_a}, 32'h0);
`endif
    step();
    we = 0;

    // Reset in the middle of a sweep
    we = 1; des = 6; data = 32'h6666; step();
    we = 0; clr = 1; step();
    clr = 0; step(); step(); step();
    chk("mid_busy_a", busy_a, 1'b1);
    #2; rst_n = 1'b0; #1;
    chk("rst_busy_a2", busy_a, 1'b0);
    chk("rst_busy_z2", busy_z, 1'b0);
    chk("rst_busy_w2", busy_w, 1'b0);
    ra1 = 6; #1;
    chk("rst_r6_a", {16'h0, rd1_a}, 32'h0);
    chk("rst_r6_w", rd1_w, 32'h0);
    chk("rst_done_a", done_a, 1'b0);
    step(); step();
    rst_n = 1'b1;
    dn_a = 0; dn_w = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (done_a) dn_a++;
      if (done_w) dn_w++;
      step();
    end
    chk("no_done_after_rst_a", dn_a, 0);
    chk("no_done_after_rst_w", dn_w, 0);

    run_cmp = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
